// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_EXT  = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[0] is the core port, req[1] the ext port.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);

    port_t r_last;

    // Grant selection: a tie goes to the port that did not win last time
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (r_last == PORT_EXT) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

    // Last-winner pointer, starts at ext so the core wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_EXT;
        end else if (grant_en && (gnt != 2'b00)) begin
            r_last <= gnt[1] ? PORT_EXT : PORT_CORE;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core MEM stage and an external loader port,
// one access at a time, with registered strobes, read data and ack pulses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    port_t             r_port;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_core_ack;
    logic              r_ext_ack;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_ext_rdata;
    logic              r_mem_wr;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;

    logic [1:0]        w_gnt;
    logic              w_grant_en;
    port_t             w_sel_port;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_grant_en = (r_state == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (reset),
        .req      ({ext_req, core_req}),
        .grant_en (w_grant_en),
        .gnt      (w_gnt)
    );

    // Mux the winning requester's fields
    always_comb begin
        w_sel_port  = PORT_CORE;
        w_sel_we    = core_we;
        w_sel_addr  = core_addr;
        w_sel_wdata = core_wdata;
        if (w_gnt[1]) begin
            w_sel_port  = PORT_EXT;
            w_sel_we    = ext_we;
            w_sel_addr  = ext_addr;
            w_sel_wdata = ext_wdata;
        end else begin
            w_sel_port  = PORT_CORE;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt != 2'b00) begin
                    w_next = ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_next = DONE;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next = DONE;
                end else begin
                    w_next = WAIT;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port       <= PORT_CORE;
            r_we         <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
            r_core_ack   <= 1'b0;
            r_ext_ack    <= 1'b0;
            r_core_rdata <= {DATA_W{1'b0}};
            r_ext_rdata  <= {DATA_W{1'b0}};
            r_mem_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_wdata  <= {DATA_W{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_core_ack  <= (w_next == DONE) && (r_port == PORT_CORE);
            r_ext_ack   <= (w_next == DONE) && (r_port == PORT_EXT);
            r_busy      <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_port      <= w_sel_port;
                        r_we        <= w_sel_we;
                        r_mem_wr    <= w_sel_we;
                        r_mem_rd    <= ~w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end else begin
                        r_port <= r_port;
                    end
                end
                ISSUE: r_cnt <= LAT_M1;
                WAIT: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        if (r_port == PORT_CORE) begin
                            r_core_rdata <= mem_rd_data;
                        end else begin
                            r_ext_rdata <= mem_rd_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1'b1);
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign core_rdata  = r_core_rdata;
    assign ext_rdata   = r_ext_rdata;
    assign core_ack    = r_core_ack;
    assign ext_ack     = r_ext_ack;
    assign core_stall  = core_req & ~r_core_ack;
    assign mem_wr      = r_mem_wr;
    assign mem_rd      = r_mem_rd;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wdata;
    assign busy        = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each with its own behavioural memory.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        req   [2][2];
    logic        we    [2][2];
    logic [8:0]  addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [31:0] rdata [2][2];
    logic        ack   [2][2];
    logic        stall [2];
    logic        mwr   [2];
    logic        mrd   [2];
    logic        busy  [2];
    logic [8:0]  maddr [2];
    logic [31:0] mwdata[2];
    logic [31:0] mrdata[2];
    logic [31:0] mem   [2][512];
    logic [31:0] pipe  [2][3];

    int cyc;
    int total;
    int bad;
    bit mon_en;

    typedef struct {
        bit          port;
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .reset(rst_n[0]),
        .core_req(req[0][0]), .core_we(we[0][0]), .core_addr(addr[0][0]), .core_wdata(wdata[0][0]),
        .core_rdata(rdata[0][0]), .core_ack(ack[0][0]), .core_stall(stall[0]),
        .ext_req(req[0][1]), .ext_we(we[0][1]), .ext_addr(addr[0][1]), .ext_wdata(wdata[0][1]),
        .ext_rdata(rdata[0][1]), .ext_ack(ack[0][1]),
        .mem_wr(mwr[0]), .mem_rd(mrd[0]), .mem_addr(maddr[0]), .mem_wr_data(mwdata[0]),
        .mem_rd_data(mrdata[0]), .busy(busy[0])
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .reset(rst_n[1]),
        .core_req(req[1][0]), .core_we(we[1][0]), .core_addr(addr[1][0]), .core_wdata(wdata[1][0]),
        .core_rdata(rdata[1][0]), .core_ack(ack[1][0]), .core_stall(stall[1]),
        .ext_req(req[1][1]), .ext_we(we[1][1]), .ext_addr(addr[1][1]), .ext_wdata(wdata[1][1]),
        .ext_rdata(rdata[1][1]), .ext_ack(ack[1][1]),
        .mem_wr(mwr[1]), .mem_rd(mrd[1]), .mem_addr(maddr[1]), .mem_wr_data(mwdata[1]),
        .mem_rd_data(mrdata[1]), .busy(busy[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memories: index 0 has one cycle of read latency, index 1 has three
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mwr[d]) mem[d][maddr[d]] <= mwdata[d];
            pipe[d][0] <= mrd[d] ? mem[d][maddr[d]] : 32'h0;
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end
    assign mrdata[0] = pipe[0][0];
    assign mrdata[1] = pipe[1][2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_check(input int d);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
            chk($sformatf("d%0d_unexpected_ack", d), {ack[d][1], ack[d][0]}, 2'b00);
        end else begin
            chk($sformatf("d%0d_ack_port", d), {ack[d][1], ack[d][0]}, e.port ? 2'b10 : 2'b01);
            chk($sformatf("d%0d_ack_cycle", d), cyc, e.cyc);
            if (e.rd) chk($sformatf("d%0d_rdata", d), rdata[d][e.port], e.data);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks strobe exclusivity each cycle
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_strobe_excl", d), mwr[d] & mrd[d], 1'b0);
                if (ack[d][0] || ack[d][1]) mon_check(d);
            end
        end
    end

    task automatic wait_ack(input int d, input int p, input int bound);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (ack[d][p]) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("d%0d_p%0d_ack_seen", d, p), seen, 1'b1);
    endtask

    task automatic access(input int d, input int p, input bit w, input logic [8:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input int lat,
                          input bit drop_early);
        int   t;
        exp_t e;
        @(posedge clk); #1;
        t      = cyc;
        e.port = p[0];
        e.rd   = ~w;
        e.data = exp_rd;
        e.cyc  = t + 2 + (w ? 0 : lat);
        push(d, e);
        req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; wdata[d][p] = wd;
        @(negedge clk);
        chk($sformatf("d%0d_stall_req", d), stall[d], (p == 0));
        @(negedge clk);
        chk($sformatf("d%0d_mem_wr", d), mwr[d], w);
        chk($sformatf("d%0d_mem_rd", d), mrd[d], !w);
        chk($sformatf("d%0d_mem_addr", d), maddr[d], a);
        chk($sformatf("d%0d_mem_wdata", d), mwdata[d], wd);
        chk($sformatf("d%0d_busy_issue", d), busy[d], 1'b1);
        if (drop_early) begin
            @(posedge clk); #1;
            req[d][p] = 1'b0;
        end
        wait_ack(d, p, 12);
        chk($sformatf("d%0d_stall_ack", d), stall[d], 1'b0);
        @(posedge clk); #1;
        req[d][p] = 1'b0;
        @(negedge clk);
        chk($sformatf("d%0d_idle_busy", d), busy[d], 1'b0);
    endtask

    task automatic sat_port(input int p, input logic [8:0] a1, input logic [31:0] w1);
        wait_ack(0, p, 20);
        @(posedge clk); #1;
        addr[0][p] = a1; wdata[0][p] = w1;
        wait_ack(0, p, 20);
        @(posedge clk); #1;
        req[0][p] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int   t;
        exp_t e;
        mon_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = 9'h0; wdata[d][p] = 32'h0;
            end
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_core_ack", ack[d][0], 1'b0);
            chk("rst_ext_ack", ack[d][1], 1'b0);
            chk("rst_mem_wr", mwr[d], 1'b0);
            chk("rst_mem_rd", mrd[d], 1'b0);
            chk("rst_mem_addr", maddr[d], 9'h0);
            chk("rst_mem_wdata", mwdata[d], 32'h0);
            chk("rst_busy", busy[d], 1'b0);
            chk("rst_core_rdata", rdata[d][0], 32'h0);
            chk("rst_ext_rdata", rdata[d][1], 32'h0);
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1; mon_en = 1'b1;

        // MEM_LAT=1: core write/read, then ext-only write/read at the top address
        access(0, 0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0, 1, 1'b0);
        access(0, 0, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF, 1, 1'b0);
        access(0, 1, 1'b1, 9'h1FF, 32'hCAFEF00D, 32'h0, 1, 1'b0);
        access(0, 1, 1'b0, 9'h1FF, 32'h0, 32'hCAFEF00D, 1, 1'b0);
        chk("core_rdata_kept", rdata[0][0], 32'hDEADBEEF);

        // Both ports saturating: strict core, ext, core, ext alternation
        @(posedge clk); #1;
        t = cyc;
        e.rd = 1'b0; e.data = 32'h0;
        e.port = 1'b0; e.cyc = t + 2;  push(0, e);
        e.port = 1'b1; e.cyc = t + 5;  push(0, e);
        e.port = 1'b0; e.cyc = t + 8;  push(0, e);
        e.port = 1'b1; e.cyc = t + 11; push(0, e);
        req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 9'h00A; wdata[0][0] = 32'h11110001;
        req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 9'h00B; wdata[0][1] = 32'h22220001;
        fork
            sat_port(0, 9'h00C, 32'h11110002);
            sat_port(1, 9'h00D, 32'h22220002);
        join
        access(0, 0, 1'b0, 9'h00D, 32'h0, 32'h22220002, 1, 1'b0);

        // Reset in WAIT of a core read: outputs clear at once, no ack afterwards
        @(posedge clk); #1;
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 9'h005;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        #1;
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_mem_rd", mrd[0], 1'b0);
        chk("midrst_mem_addr", maddr[0], 9'h0);
        chk("midrst_core_ack", ack[0][0], 1'b0);
        chk("midrst_core_rdata", rdata[0][0], 32'h0);
        chk("midrst_ext_rdata", rdata[0][1], 32'h0);
        @(posedge clk); #1;
        req[0][0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        repeat (3) @(posedge clk);

        // First tie after reset goes to the core even though core won last before reset
        @(posedge clk); #1;
        t = cyc;
        e.port = 1'b0; e.rd = 1'b1; e.data = 32'hDEADBEEF; e.cyc = t + 3; push(0, e);
        e.port = 1'b1; e.rd = 1'b0; e.data = 32'h0;        e.cyc = t + 6; push(0, e);
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 9'h005; wdata[0][0] = 32'h0;
        req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 9'h0AA; wdata[0][1] = 32'h12345678;
        fork
            begin wait_ack(0, 0, 10); @(posedge clk); #1; req[0][0] = 1'b0; end
            begin wait_ack(0, 1, 12); @(posedge clk); #1; req[0][1] = 1'b0; end
        join

        // MEM_LAT=3: write/read, then a core read that drops req during WAIT
        access(1, 0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0, 3, 1'b0);
        access(1, 0, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        access(1, 1, 1'b1, 9'h020, 32'h0BADF00D, 32'h0, 3, 1'b0);
        access(1, 0, 1'b0, 9'h020, 32'h0, 32'h0BADF00D, 3, 1'b1);
        repeat (4) @(posedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
